fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

- Downstream consumer of the 16-deep byte FIFO: drains bytes through the FIFO's read port and serializes each onto an asynchronous UART line (8N1 by default; parity and stop-bit count configurable).
- Owns the FIFO's read strobe and honours the FIFO's write-over-read priority, so no byte is lost or duplicated.
- Sits between the FIFO and the chip-level TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range ≥ 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_en  in  1  when high, fetch and send bytes; when low, finish the current frame, then idle.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_wr  in  1  tap of the FIFO write strobe; a read collides with it.
- fifo_dout  in  8  FIFO registered read data.
- fifo_rd  out  1  FIFO read strobe.
- tx  out  1  serial line; idle high.
- busy  out  1  high in every state except IDLE.
- byte_done  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- **Read acceptance.** A read is accepted at a rising edge when fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full). A write always wins in the FIFO, so a colliding read is silently dropped.
- **fifo_rd** is a Moore output: high only in FETCH.

State machine:
- **IDLE** → FETCH when tx_en && !fifo_empty.
- **FETCH** → LOAD on an accepted read.
  - Otherwise stay in FETCH, holding fifo_rd high.
  - If fifo_empty rises, or tx_en falls, before acceptance, return to IDLE.
- **LOAD** (1 cycle)
  - Capture fifo_dout into an 8-bit shift register; it is valid in the cycle after acceptance.
  - Compute parity: even = XOR of the data bits; odd = its inverse.
  - Go to START.
- **START**: tx = 0 for CLKS_PER_BIT cycles → DATA.
- **DATA**: 8 bits, LSB first, each CLKS_PER_BIT cycles; a 3-bit bit counter runs 0..7.
  - When the count reaches 7 and the bit time ends: go to PARITY if PARITY != 0, else STOP.
- **PARITY**: tx = parity bit for one bit time → STOP.
- **STOP**: tx = 1 for STOP_BITS bit times.
  - Pulse byte_done in the final cycle.
  - Go to FETCH if tx_en && !fifo_empty, else IDLE.

Other rules:
- The baud counter is ceil(log2(CLKS_PER_BIT)) bits wide. It counts 0..CLKS_PER_BIT-1, clears at every state entry and wraps at the end of each bit.
- Mid-frame changes to tx_en, fifo_empty or fifo_dout have no effect on the frame in flight.

## Timing
- **Reset** (asynchronous, immediate): state = IDLE, tx = 1, fifo_rd = 0, busy = 0, byte_done = 0, shift register and counters = 0.
  - Reset mid-frame truncates the frame and drives the line high at once.
  - The FIFO contents are untouched.
- **Latency**, fifo_empty falling (tx_en high) to tx falling:
  - The next edge enters FETCH.
  - With no write collision, acceptance occurs at the following edge.
  - The LOAD edge follows; START begins the cycle after it.
  - Total: 3 cycles.
- **Frame length**: (1 + 8 + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Back-to-back gap**: at least 2 extra idle-high cycles (FETCH, LOAD) between frames. This is legal as an extended stop.
- **Write collision**: each colliding cycle adds one cycle of FETCH. The byte read is the same one that would have been read otherwise.
- tx and fifo_rd are registered (no combinational path from the inputs).
- byte_done is registered.

## Structure
- Package fifo_uart_pkg:
  - state enum (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - DATA_W = 8.
- Sub-module uart_baud_gen: parameter CLKS_PER_BIT; inputs clk, rst_n, clr; output bit_end, a pulse on the last cycle of each bit.

## Test plan
- **Reset values.** Assert rst_n=0 mid-frame, during DATA bit 3 → in the same cycle, tx=1, busy=0, fifo_rd=0. After release, stays IDLE while fifo_empty=1.
- **Single frame.** CLKS_PER_BIT=4, PARITY=0, FIFO holds 0xA5 → tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles. fifo_rd is high for exactly 1 cycle. byte_done pulses once. Total 40 cycles from start edge to the end of the stop bit.
- **Even parity.** PARITY=1, byte 0x07 → parity bit 1. PARITY=2, byte 0x07 → parity bit 0.
- **Collision.** fifo_wr=1 and fifo_full=0 for 3 cycles while in FETCH → fifo_rd stays high 4 cycles. Exactly one byte is sent. FIFO count drops by 1 relative to the writes.
- **Back-to-back drain.** FIFO holds 0x11, 0x22, 0x33, STOP_BITS=2 → three frames in order, 2-cycle idle gaps between them, three byte_done pulses. Ends IDLE with fifo_empty=1.
- **tx_en drop.** Deassert tx_en during DATA with 2 bytes queued → the current frame completes. No further fifo_rd. 1 byte remains in the FIFO.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-draining UART transmitter.
//   state_t  : transmitter FSM states
//   PAR_*    : parity mode encodings for the PARITY parameter
//   DATA_W   : width of one serialized character
//   parity_bit() : parity bit for a data byte under a given mode
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package fifo_uart_pkg;

    localparam int DATA_W = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Even parity makes the total count of ones (data + parity) even, so the
    // bit is simply the XOR of the data; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input int mode);
        logic p;
        p = ^d;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-side view of the 16-deep byte FIFO as seen by its consumer.
//   fifo_empty : FIFO empty flag
//   fifo_full  : FIFO full flag
//   fifo_wr    : tap of the FIFO write strobe (a write beats a read)
//   fifo_dout  : FIFO registered read data
//   fifo_rd    : read strobe driven by the consumer
// Modports: master = the reading consumer, slave = the FIFO.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_full,
        input  fifo_wr,
        input  fifo_dout,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_full,
        output fifo_wr,
        output fifo_dout,
        input  fifo_rd
    );

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-time counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps; bit_end marks the last clock of each bit.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear, asserted on every FSM state change so each
//             state starts with a full bit time
//   bit_end : high during the final cycle of the current bit
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains bytes from a 16-deep FIFO and serializes them onto a UART line
// (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   tx_en     : fetch and send while high; when low the current frame finishes
//   fif       : FIFO read port (empty/full/wr tap/dout in, rd out)
//   tx        : serial line, idle high
//   busy      : high whenever the FSM is not idle
//   byte_done : one-cycle pulse in the last cycle of the final stop bit
// Parameters: CLKS_PER_BIT (>= 2), PARITY (0 none, 1 even, 2 odd),
//             STOP_BITS (1 or 2).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    fifo_uart_tx_if.master       fif,
    output logic                 tx,
    output logic                 busy,
    output logic                 byte_done
);

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] shreg;
    logic              par_q;
    logic [2:0]        bit_cnt;
    logic              bit_end;
    logic              clr;
    logic              rd_ok;
    logic              last_stop;

    // The FIFO gives a simultaneous write priority, so a read strobe issued
    // while a write lands is dropped and must be repeated next cycle.
    assign rd_ok     = !fif.fifo_empty && !(fif.fifo_wr && !fif.fifo_full);
    assign last_stop = (bit_cnt == STOP_LAST);

    // Restart the bit timer whenever the state changes.
    assign clr = (state_nx != state);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (tx_en && !fif.fifo_empty) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                // An accepted read must be consumed even if tx_en just fell,
                // otherwise the popped byte would be lost.
                if (rd_ok)                            state_nx = ST_LOAD;
                else if (fif.fifo_empty || !tx_en)    state_nx = ST_IDLE;
            end
            ST_LOAD: begin
                state_nx = ST_START;
            end
            ST_START: begin
                if (bit_end) state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == 3'd7)) begin
                    state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end && last_stop) begin
                    state_nx = (tx_en && !fif.fifo_empty) ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // bit_cnt indexes data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            par_q   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if (clr) begin
                bit_cnt <= '0;
            end else if (bit_end && (state == ST_DATA || state == ST_STOP)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // fifo_dout is registered in the FIFO, so it holds the accepted
            // byte during LOAD.
            if (state == ST_LOAD) begin
                shreg <= fif.fifo_dout;
                par_q <= parity_bit(fif.fifo_dout, PARITY);
            end else if (state == ST_DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
        end
    end

    // Outputs decode registered state only; no input reaches them
    // combinationally, and reset forces the line high immediately.
    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shreg[0];
            ST_PARITY: tx = par_q;
            default:   tx = 1'b1;
        endcase
    end

    assign fif.fifo_rd = (state == ST_FETCH);
    assign busy        = (state != ST_IDLE);
    assign byte_done   = (state == ST_STOP) && bit_end && last_stop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int CPB = 4;
    localparam int N   = 3;
    localparam int PAR_CFG  [N] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
    localparam int STOP_CFG [N] = '{1, 2, 1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0] tx_en_v = '0;
    logic [N-1:0] f_wr    = '0;
    logic [N-1:0] f_empty = '1;
    logic [N-1:0] f_full  = '0;
    logic [7:0]   f_wdata [N] = '{default: 8'h00};
    logic [7:0]   f_dout  [N] = '{default: 8'h00};
    logic [N-1:0] rd_v;
    logic [N-1:0] tx_v;
    logic [N-1:0] busy_v;
    logic [N-1:0] done_v;

    logic [7:0] fq [N][$];
    int rd_cnt   [N] = '{default: 0};
    int done_cnt [N] = '{default: 0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        fifo_uart_tx_if fif ();
        assign fif.fifo_empty = f_empty[g];
        assign fif.fifo_full  = f_full[g];
        assign fif.fifo_wr    = f_wr[g];
        assign fif.fifo_dout  = f_dout[g];
        assign rd_v[g]        = fif.fifo_rd;

        fifo_uart_tx #(
            .CLKS_PER_BIT (CPB),
            .PARITY       (PAR_CFG[g]),
            .STOP_BITS    (STOP_CFG[g])
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_en     (tx_en_v[g]),
            .fif       (fif),
            .tx        (tx_v[g]),
            .busy      (busy_v[g]),
            .byte_done (done_v[g])
        );
    end

    // Behavioural FIFO: write wins over a simultaneous read; registered dout.
    always @(posedge clk) begin : fifo_model
        logic wr_ok, rd_ok;
        for (int i = 0; i < N; i++) begin
            wr_ok = f_wr[i] && (fq[i].size() < 16);
            rd_ok = rd_v[i] && (fq[i].size() > 0) && !wr_ok;
            if (rd_ok) f_dout[i] <= fq[i].pop_front();
            if (wr_ok) fq[i].push_back(f_wdata[i]);
            f_empty[i] <= (fq[i].size() == 0);
            f_full[i]  <= (fq[i].size() >= 16);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_v[i])   rd_cnt[i]++;
            if (done_v[i]) done_cnt[i]++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int i, input logic [7:0] b);
        f_wdata[i] = b;
        f_wr[i]    = 1'b1;
        @(negedge clk);
        f_wr[i]    = 1'b0;
    endtask

    // Waits for the start bit on instance i, then checks every cycle of the
    // frame against bit values derived from the byte. exp_w >= 0 also checks
    // the number of cycles waited; drop_k >= 0 lowers tx_en at that cycle.
    task automatic expect_frame(input int i, input logic [7:0] b,
                                input int drop_k, input int exp_w);
        logic [11:0] bits;
        int nb, len, w;
        nb   = 9 + ((PAR_CFG[i] != PAR_NONE) ? 1 : 0) + STOP_CFG[i];
        len  = nb * CPB;
        bits = '1;
        bits[0] = 1'b0;
        for (int j = 0; j < 8; j++) bits[1+j] = b[j];
        if (PAR_CFG[i] == PAR_EVEN) bits[9] = ($countones(b) % 2) == 1;
        if (PAR_CFG[i] == PAR_ODD)  bits[9] = ($countones(b) % 2) == 0;
        w = 0;
        while (tx_v[i] !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (tx_v[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_bit[%0d]: tx=%b after %0d cycles, required 0", i, tx_v[i], w);
            return;
        end
        if (exp_w >= 0) begin
            n_checks++;
            if (w != exp_w) begin
                n_fail++;
                $display("FAIL start_latency[%0d]: got %0d cycles, required %0d", i, w, exp_w);
            end
        end
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_k) tx_en_v[i] = 1'b0;
            n_checks++;
            if (tx_v[i] !== bits[k/CPB] || done_v[i] !== (k == len - 1) || busy_v[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL frame[%0d] byte %h cycle %0d: tx/done/busy=%b%b%b required %b%b1",
                         i, b, k, tx_v[i], done_v[i], busy_v[i], bits[k/CPB], (k == len - 1));
            end
        end
    endtask

    task automatic test_reset();
        cycles(3);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({tx_v[i], busy_v[i], rd_v[i], done_v[i]} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_values[%0d]: tx/busy/rd/done=%b%b%b%b required 1000",
                         i, tx_v[i], busy_v[i], rd_v[i], done_v[i]);
            end
        end
        rst_n = 1'b1;
        tx_en_v = '1;
        cycles(6);
        n_checks++;
        if (busy_v !== '0 || rd_v !== '0) begin
            n_fail++;
            $display("FAIL idle_when_empty: busy=%b rd=%b required 000/000", busy_v, rd_v);
        end
        tx_en_v = '0;
    endtask

    task automatic test_single_frame();
        int r0, d0;
        r0 = rd_cnt[0];
        d0 = done_cnt[0];
        tx_en_v[0] = 1'b1;
        push(0, 8'hA5);
        expect_frame(0, 8'hA5, -1, 3);
        cycles(4);
        n_checks++;
        if (rd_cnt[0] - r0 != 1 || done_cnt[0] - d0 != 1 || busy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_frame: rd cycles %0d done pulses %0d busy %b, required 1 1 0",
                     rd_cnt[0] - r0, done_cnt[0] - d0, busy_v[0]);
        end
        tx_en_v[0] = 1'b0;
    endtask

    task automatic test_parity();
        for (int i = 1; i < N; i++) begin
            tx_en_v[i] = 1'b1;
            push(i, 8'h07);
            expect_frame(i, 8'h07, -1, 3);
            cycles(3);
            tx_en_v[i] = 1'b0;
        end
    endtask

    task automatic test_collision();
        logic [7:0] wb [3];
        int r0;
        push(0, 8'h3C);
        r0 = rd_cnt[0];
        tx_en_v[0] = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            wb[c] = 8'($urandom);
            f_wdata[0] = wb[c];
            f_wr[0] = 1'b1;
            @(negedge clk);
        end
        f_wr[0] = 1'b0;
        expect_frame(0, 8'h3C, 2 * CPB, -1);
        cycles(8);
        n_checks++;
        if (rd_cnt[0] - r0 != 4 || fq[0].size() != 3 || busy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL collision: rd cycles %0d fifo count %0d busy %b, required 4 3 0",
                     rd_cnt[0] - r0, fq[0].size(), busy_v[0]);
        end
        tx_en_v[0] = 1'b1;
        for (int c = 0; c < 3; c++) expect_frame(0, wb[c], -1, 3);
        cycles(4);
        tx_en_v[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int d0;
        push(1, 8'h11);
        push(1, 8'h22);
        push(1, 8'h33);
        d0 = done_cnt[1];
        tx_en_v[1] = 1'b1;
        expect_frame(1, 8'h11, -1, 3);
        expect_frame(1, 8'h22, -1, 3);
        expect_frame(1, 8'h33, -1, 3);
        cycles(4);
        n_checks++;
        if (done_cnt[1] - d0 != 3 || busy_v[1] !== 1'b0 || f_empty[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back: done pulses %0d busy %b empty %b, required 3 0 1",
                     done_cnt[1] - d0, busy_v[1], f_empty[1]);
        end
        tx_en_v[1] = 1'b0;
    endtask

    task automatic test_txen_drop();
        logic [7:0] a, b;
        int r0;
        a = 8'($urandom);
        b = 8'($urandom);
        push(0, a);
        push(0, b);
        r0 = rd_cnt[0];
        tx_en_v[0] = 1'b1;
        expect_frame(0, a, 3 * CPB, 3);
        cycles(20);
        n_checks++;
        if (rd_cnt[0] - r0 != 1 || fq[0].size() != 1 || busy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL txen_drop: rd cycles %0d fifo count %0d busy %b, required 1 1 0",
                     rd_cnt[0] - r0, fq[0].size(), busy_v[0]);
        end
        tx_en_v[0] = 1'b1;
        expect_frame(0, b, -1, 3);
        cycles(3);
        tx_en_v[0] = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            tx_en_v[i] = 1'b1;
            for (int n = 0; n < 4; n++) begin
                b = 8'($urandom);
                push(i, b);
                expect_frame(i, b, -1, 3);
            end
            cycles(3);
            tx_en_v[i] = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        int w, r0;
        tx_en_v[0] = 1'b1;
        push(0, 8'($urandom));
        w = 0;
        while (tx_v[0] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        // Skip the start bit and data bits 0..2, landing inside bit 3.
        cycles(4 * CPB + 1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_v[0], busy_v[0], rd_v[0], done_v[0]} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_midframe: tx/busy/rd/done=%b%b%b%b required 1000",
                     tx_v[0], busy_v[0], rd_v[0], done_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rd_cnt[0];
        cycles(10);
        n_checks++;
        if (busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || rd_cnt[0] != r0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy %b tx %b rd cycles %0d, required 0 1 0",
                     busy_v[0], tx_v[0], rd_cnt[0] - r0);
        end
        tx_en_v[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_collision();
        test_back_to_back();
        test_txen_drop();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
